uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//   Serial transmitter producing the line that uart_rx samples; loopback partner for uart_rx in tb.
//   Accepts one parallel byte per start strobe and shifts it out as a UART frame: start, data LSB first, optional parity, stop.
//   Default framing is 8N1, matching uart_rx.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit (>=2); must equal the uart_rx bit period
//   DATA_BITS     8   data bits per frame (5..8)
//   PARITY        0   0 none, 1 even, 2 odd
//   STOP_BITS     1   stop bits (1 or 2)
// PORTS
//   clk   in   1          system clock, rising edge
//   rst   in   1          asynchronous reset, active low
//   en    in   1          start strobe; sampled only while busy==0
//   data  in   DATA_BITS  byte to send; captured on the accepted en cycle
//   tx    out  1          serial line, idle high
//   busy  out  1          high from the cycle after acceptance until the frame ends
// BEHAVIOUR
//   Reset (rst==0, async): tx=1, busy=0, state=IDLE, counters=0, shift reg=0. Release is synchronous to the next clk edge.
//   Accept: en==1 && busy==0 at a clk edge -> data latched into shift reg, state=START.
//     tx=0 and busy=1 are registered outputs, so both change after that same edge (1-cycle latency).
//   en while busy==1 is ignored; data changes after acceptance have no effect on the frame.
//   States: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
//   Each state holds tx for exactly CLKS_PER_BIT cycles, timed by bit tick (bit counter == CLKS_PER_BIT-1).
//   DATA: shift right on each bit tick; tx = shift[0]; bit index 0..DATA_BITS-1; leave DATA after index DATA_BITS-1.
//   PARITY: tx = ^data_latched for even, ~^data_latched for odd.
//   STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; at the final tick go to IDLE with busy=0.
//   Frame length F = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles. busy is high for exactly F cycles.
//   Back-to-back: en asserted on the first cycle busy==0 starts the next frame with no extra idle bit.
//     Min start-to-start spacing is F+1 cycles.
//   Bit counter width is $clog2(CLKS_PER_BIT). It resets to 0 on every state change and never wraps mid-bit.
//   rst asserted mid-frame aborts immediately: tx=1, busy=0. No partial frame resumes after release.
//   tx is driven straight from a flop: glitch-free, no combinational path from en/data to tx.
// STRUCTURE
//   uart_pkg (shared with uart_rx):
//     typedef enum logic [2:0] {IDLE,START,DATA,PARITY,STOP} uart_state_t
//     localparams PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
//   Sub-module uart_baud_gen #(CLKS_PER_BIT) (clk, rst, clr, tick):
//     free-running bit counter; clr restarts it; tick is high on count CLKS_PER_BIT-1.
//     uart_rx reuses it at half-bit offset.
//   Top-level: FSM, shift register, stop-bit counter, parity flop.
// TESTING
//   1. Reset then idle 50 cycles, en=0 -> tx==1, busy==0 throughout.
//   2. en=1 for 1 cycle, data=8'h55, CLKS_PER_BIT=16.
//      -> tx shows 0,1,0,1,0,1,0,1,0,1, each 16 cycles; busy high exactly 160 cycles.
//   3. Loopback tx->uart_rx.rx, send 8'hA3.
//      -> uart_rx en pulses once with data==8'hA3; busy of both return to 0.
//   4. en held high across frames with data 8'h00 then 8'hFF.
//      -> en ignored while busy; second frame starts the cycle after busy falls; spacing 161 cycles.
//   5. PARITY=1, data=8'h07 -> parity bit 1; PARITY=2, same data -> parity bit 0.
//   6. rst pulsed low at cycle 70 of a frame.
//      -> tx=1, busy=0 within the same cycle; next en sends a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART transmitter and receiver: the frame
//   state encoding and the parity mode selectors.
//   No ports; import with "import uart_pkg::*;".
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// UartBaudGen (module uart_baud_gen)
//   Free-running bit-period counter. It produces a one-cycle tick at the
//   last cycle of every serial bit. The receiver reuses it with a half-bit
//   offset, so the counter restarts from zero whenever clr is high.
// Ports
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active low
//   clr   in   hold/restart the counter at zero
//   tick  out  high while the count equals CLKS_PER_BIT-1
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

   // The counter wraps to zero on its own tick rather than overflowing.
   // This keeps every bit exactly CLKS_PER_BIT cycles long even when
   // CLKS_PER_BIT is not a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UartTx (module uart_tx)
//   Serial transmitter. It accepts one parallel word per start strobe and
//   shifts it out as start bit, data LSB first, optional parity bit, and
//   stop bit(s). tx and busy come straight from flops, so tx never glitches
//   and has no combinational path from en or data.
// Ports
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active low
//   en    in   start strobe, looked at only while busy is low
//   data  in   word to send, captured on the accepted en cycle
//   tx    out  serial line, idle high
//   busy  out  high from the cycle after acceptance until the frame ends
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy
);

   localparam int IW = $clog2(DATA_BITS);

   uart_state_t          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic                 par_q, par_d;
   logic                 tx_d, busy_d;
   logic                 tick;

   // The bit counter is held at zero while idle. Every later state change
   // happens on a tick, where the counter wraps to zero by itself, so each
   // state starts its bit period from a zero count.
   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) baudGen (
      .clk (clk),
      .rst (rst),
      .clr (state_q == IDLE),
      .tick(tick)
   );

   // State and datapath registers. tx and busy are registered here so that
   // both change on the clock edge after the decision that sets them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         par_q   <= 1'b0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         par_q   <= par_d;
         tx      <= tx_d;
         busy    <= busy_d;
      end
   end

   // Next-state logic. tx_d is the value the line must carry in the bit
   // being entered. For that reason, on a data tick it takes shift_q[1],
   // which is the new LSB after the right shift. The parity of the captured
   // word is computed once at acceptance, so later changes on data cannot
   // reach the frame. The PARITY state name is scoped explicitly because the
   // PARITY parameter hides the imported name.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      par_d   = par_q;
      tx_d    = tx;
      busy_d  = busy;
      case (state_q)
         IDLE: begin
            if (en) begin
               shift_d = data;
               par_d   = (PARITY == PAR_ODD) ? ~^data : ^data;
               idx_d   = '0;
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (idx_q == IW'(DATA_BITS - 1)) begin
                  if (PARITY != PAR_NONE) begin
                     state_d = uart_pkg::PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     stop_d  = 1'b0;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + IW'(1);
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         uart_pkg::PARITY: begin
            if (tick) begin
               state_d = STOP;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (tick) begin
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule
